// File: rtl/mem_ctrl.sv
// Single-port 4096x16 memory controller with programmable wait states.
// A request is taken in IDLE, waits WAIT_CYCLES cycles, then performs one access cycle.
module mem_ctrl #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        REST_N,
   input  logic [11:0] ADDR_IN,
   input  logic [15:0] DATA_IN,
   input  logic        RD,
   input  logic        WR,
   output logic [15:0] DATA_OUT,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR
);

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        accept;
   logic        req_err;
   logic        req_wr_p0;
   logic [11:0] req_addr_p0;
   logic [15:0] req_data_p0;
   logic [15:0] mem [0:4095];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      req_err   = 1'b0;
      case (state)
         IDLE: begin
            if (RD ^ WR) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_nxt = ACCESS;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = WAIT_LD;
               end
            end else if (RD && WR) begin
               req_err = 1'b1;
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 4'd1;
            // Leave on the edge where the counter lands on zero.
            if (cnt <= 4'd1) begin
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge REST_N) begin
      if (!REST_N) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         req_wr_p0 <= 1'b0;
         DONE      <= 1'b0;
         ERR       <= 1'b0;
         DATA_OUT  <= 16'h0000;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         DONE  <= (state == ACCESS);
         ERR   <= req_err;
         if (accept) begin
            req_wr_p0 <= WR;
         end
         if ((state == ACCESS) && !req_wr_p0) begin
            DATA_OUT <= mem[req_addr_p0];
         end
      end
   end

   // Request capture and storage: datapath only, untouched by reset so contents survive it.
   always_ff @(posedge clk) begin
      if (accept) begin
         req_addr_p0 <= ADDR_IN;
         req_data_p0 <= DATA_IN;
      end
      if ((state == ACCESS) && req_wr_p0) begin
         mem[req_addr_p0] <= req_data_p0;
      end
   end

   assign BUSY = (state != IDLE);

endmodule
